// File: rtl/distributor.sv
// distributor: 4-phase bundled-data 1-to-2 router with drop/single/broadcast select.
// Define DISTRIBUTOR_SYNC_EN to add 2-flop synchronizers on r_i, a_o and a1_o.
module distributor #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r_i,
    output logic         a_i,
    input  logic [N-1:0] d_i,
    input  logic [1:0]   s_i,
    output logic         r_o,
    input  logic         a_o,
    output logic [N-1:0] d_o,
    output logic         r1_o,
    input  logic         a1_o,
    output logic [N-1:0] d1_o
);
    typedef enum logic [1:0] {IDLE, SEND, RTZ} state_t;
    state_t       state;
    logic [N-1:0] hold_d;
    logic [1:0]   hold_s;
    logic         done0, done1;
    logic         req, ack0, ack1;
    logic         nd0, nd1;
`ifdef DISTRIBUTOR_SYNC_EN
    logic [2:0] sync1, sync2;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {r_i, a_o, a1_o};
            sync2 <= sync1;
        end
    end
    assign {req, ack0, ack1} = sync2;
`else
    assign {req, ack0, ack1} = {r_i, a_o, a1_o};
`endif
    // an ack only counts while its own request is outstanding
    assign nd0 = done0 | (r_o & ack0);
    assign nd1 = done1 | (r1_o & ack1);
    assign d_o  = hold_d;
    assign d1_o = hold_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            hold_d <= '0;
            hold_s <= '0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            r_o    <= 1'b0;
            r1_o   <= 1'b0;
            a_i    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    hold_d <= d_i;
                    hold_s <= s_i;
                    r_o    <= s_i[0];
                    r1_o   <= s_i[1];
                    state  <= SEND;
                end
                SEND: begin
                    done0 <= nd0;
                    done1 <= nd1;
                    if (r_o & ack0) r_o <= 1'b0;
                    if (r1_o & ack1) r1_o <= 1'b0;
                    // unselected outputs count as done, so a drop finishes one edge after capture
                    if ((nd0 | ~hold_s[0]) & (nd1 | ~hold_s[1])) begin
                        a_i   <= 1'b1;
                        state <= RTZ;
                    end
                end
                RTZ: if (!req && !(hold_s[0] & ack0) && !(hold_s[1] & ack1)) begin
                    a_i   <= 1'b0;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
